// File: rtl/uart_cmd_framer.sv
// ============================================================================
// Module      : uart_cmd_framer
// Description : Parses 4-byte UART command frames (A5, opcode, arg, xor chk),
//               drives SoC clock/reset/TX-select/RX-gate controls and answers
//               every frame with one response byte. Optional macro
//               CMD_TIMEOUT_EN adds an inter-byte timeout on partial frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_framer #(
    parameter int RST_UNIT       = 16,
    parameter int TIMEOUT_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       soc_clk_en,
    output logic       soc_reset,
    output logic       tx_sel_ctrl,
    output logic       soc_rx_block,
    output logic [7:0] err_count
);

    localparam logic [7:0]  c_sync     = 8'hA5;
    localparam logic [7:0]  c_ack      = 8'h06;
    localparam logic [7:0]  c_nak      = 8'h15;
    localparam logic [7:0]  c_op_stat  = 8'h08;
    localparam logic [23:0] c_rst_unit = 24'(RST_UNIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_OPC  = 3'd1,
        S_ARG  = 3'd2,
        S_CHK  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_opcode;
    logic [7:0]  r_arg;
    logic [7:0]  r_resp;
    logic        r_clk_en;
    logic        r_tx_sel;
    logic        r_rx_block;
    logic [7:0]  r_err;
    logic [23:0] r_rst_cnt;

    logic        w_frame_done;
    logic        w_chk_ok;
    logic        w_known;
    logic        w_is_stat;
    logic        w_exec;
    logic        w_err_inc;
    logic        w_timeout;
    logic [23:0] w_rst_len;
    logic [7:0]  w_status;

    assign w_frame_done = (r_state == S_CHK) && rx_valid;
    assign w_chk_ok     = (rx_data == (r_opcode ^ r_arg));
    assign w_known      = (r_opcode <= 8'h07);
    assign w_is_stat    = (r_opcode == c_op_stat);
    assign w_exec       = w_frame_done && w_chk_ok && w_known;
    assign w_err_inc    = (w_frame_done && !(w_chk_ok && (w_known || w_is_stat))) || w_timeout;
    assign w_rst_len    = (24'(r_arg) + 24'd1) * c_rst_unit;
    assign w_status     = {4'h8, soc_reset, r_rx_block, r_tx_sel, r_clk_en};

`ifdef CMD_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_to_w-1:0] r_to_cnt;

    // Counts idle cycles between bytes of a partially received frame.
    always_ff @(posedge clk) begin
        if (reset || rx_valid || (r_state == S_IDLE) || (r_state == S_RESP)) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = ((r_state == S_OPC) || (r_state == S_ARG) || (r_state == S_CHK)) &&
                       !rx_valid && (r_to_cnt == c_to_w'(TIMEOUT_CYCLES - 1));
`else
    // Partial frames wait forever; the parameter only matters with the timeout build.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        tx_en        = 1'b0;
        case (r_state)
            S_IDLE: if (rx_valid && (rx_data == c_sync)) w_state_next = S_OPC;
            S_OPC:  if (rx_valid) w_state_next = S_ARG;
            S_ARG:  if (rx_valid) w_state_next = S_CHK;
            S_CHK:  if (rx_valid) w_state_next = S_RESP;
            S_RESP: begin
                if (!tx_busy) begin
                    tx_en        = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_opcode   <= 8'h00;
            r_arg      <= 8'h00;
            r_resp     <= 8'h00;
            r_clk_en   <= 1'b1;
            r_tx_sel   <= 1'b0;
            r_rx_block <= 1'b0;
            r_err      <= 8'h00;
        end else begin
            if ((r_state == S_OPC) && rx_valid) r_opcode <= rx_data;
            if ((r_state == S_ARG) && rx_valid) r_arg    <= rx_data;
            if (w_frame_done) begin
                if (w_exec)                      r_resp <= c_ack;
                else if (w_chk_ok && w_is_stat)  r_resp <= w_status;
                else                             r_resp <= c_nak;
            end
            if (w_exec) begin
                case (r_opcode[2:0])
                    3'd0:    r_clk_en   <= 1'b0;
                    3'd1:    r_clk_en   <= 1'b1;
                    3'd4:    r_tx_sel   <= 1'b0;
                    3'd5:    r_tx_sel   <= 1'b1;
                    3'd6:    r_rx_block <= 1'b0;
                    3'd7:    r_rx_block <= 1'b1;
                    default: ;
                endcase
            end
            if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
        end
    end

    // Reset pulse: soc_reset is high exactly while the down-counter is non-zero,
    // so a reload or an abort takes effect without a gap or glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rst_cnt <= 24'd0;
        end else if (w_exec && (r_opcode == 8'h02)) begin
            r_rst_cnt <= w_rst_len;
        end else if (w_exec && (r_opcode == 8'h03)) begin
            r_rst_cnt <= 24'd0;
        end else if (r_rst_cnt != 24'd0) begin
            r_rst_cnt <= r_rst_cnt - 24'd1;
        end
    end

    assign soc_reset    = (r_rst_cnt != 24'd0);
    assign tx_data      = r_resp;
    assign soc_clk_en   = r_clk_en;
    assign tx_sel_ctrl  = r_tx_sel;
    assign soc_rx_block = r_rx_block;
    assign err_count    = r_err;

endmodule

`default_nettype wire
